lmsm_sequencer: RTL and testbench

//  Multi-cycle sequencer for LM (4'b0110) and SM (4'b0111) in the decode stage.
//  - Accepts one LM/SM instruction and walks its 8-bit register list IR[7:0] lowest bit first.
//  - Emits one register-address / memory-address beat per transfer to the pipeline behind decode.
//  - Holds fetch/decode stalled until the last beat has been accepted.

---
 rtl/lmsm_sequencer_pkg.sv | 21 ++
 rtl/lmsm_sequencer_lsb_pri_enc8.sv | 23 ++
 rtl/lmsm_sequencer.sv | 157 +++++++++++++++
 tb/tb_lmsm_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/lmsm_sequencer_pkg.sv
// Shared constants and state encoding for the LM/SM multi-cycle sequencer.
// The ST_WB state exists only when LMSM_BASE_WB_EN is defined.
package lmsm_sequencer_pkg;

  localparam logic [3:0] OP_LM  = 4'b0110;
  localparam logic [3:0] OP_SM  = 4'b0111;
  localparam logic [2:0] R7_IDX = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
`ifdef LMSM_BASE_WB_EN
    ST_WB     = 2'd2,
`endif
    ST_ACTIVE = 2'd1
  } state_e;

  function automatic logic is_lmsm(input logic [3:0] opcode);
    return (opcode == OP_LM) || (opcode == OP_SM);
  endfunction

endpackage

// File: rtl/lmsm_sequencer_lsb_pri_enc8.sv
// Lowest-set-bit priority encoder (8-to-3 by default) with an any-bit flag.
module lsb_pri_enc8 #(
  parameter int W  = 8,
  parameter int AW = 3
) (
  input  logic [W-1:0]  req_i,
  output logic [AW-1:0] idx_o,
  output logic          any_o
);

  // NOTE: every combinational output gets a default before any conditional
  // assignment, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    idx_o = '0;
    // Scan downward so the lowest set bit is the final (winning) assignment.
    for (int i = W - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = AW'(i);
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/lmsm_sequencer.sv
// LM/SM sequencer: walks the register list lowest bit first, one beat per transfer.
// Define LMSM_BASE_WB_EN to append a base-register write-back beat (adds wb_valid).
module lmsm_sequencer
  import lmsm_sequencer_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int LIST_W = 8,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_ir,
  input  logic [DATA_W-1:0] in_base,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REG_AW-1:0] out_reg,
  output logic [DATA_W-1:0] out_addr,
  output logic              out_is_load,
  output logic              out_last,
`ifdef LMSM_BASE_WB_EN
  output logic              wb_valid,
`endif
  output logic              stall,
  output logic              r7_hit
);

  state_e              state_q, state_d;
  logic [LIST_W-1:0]   list_q, list_d;
  logic [DATA_W-1:0]   base_q, base_d;
  logic [REG_AW:0]     count_q, count_d;
  logic                is_load_q, is_load_d;
`ifdef LMSM_BASE_WB_EN
  logic [REG_AW-1:0]   ra_q, ra_d;
`endif

  logic [REG_AW-1:0]   enc_idx;
  logic                enc_any;
  logic [LIST_W-1:0]   clr_mask;
  logic                list_single;
  logic [DATA_W-1:0]   beat_addr;
  logic                unused_ir;

  lsb_pri_enc8 #(.W(LIST_W), .AW(REG_AW)) u_enc (
    .req_i (list_q),
    .idx_o (enc_idx),
    .any_o (enc_any)
  );

  assign clr_mask    = LIST_W'(1) << enc_idx;
  assign list_single = enc_any && ((list_q & (list_q - LIST_W'(1))) == '0);
  assign beat_addr   = base_q + DATA_W'(count_q);
  assign unused_ir   = ^in_ir;

  always_comb begin
    state_d     = state_q;
    list_d      = list_q;
    base_d      = base_q;
    count_d     = count_q;
    is_load_d   = is_load_q;
`ifdef LMSM_BASE_WB_EN
    ra_d        = ra_q;
    wb_valid    = 1'b0;
`endif
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_reg     = '0;
    out_addr    = '0;
    out_is_load = 1'b0;
    out_last    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        // An empty list is consumed here as a NOP: nothing latched, no beat.
        if (in_valid && is_lmsm(in_ir[15:12]) && (in_ir[LIST_W-1:0] != '0)) begin
          list_d    = in_ir[LIST_W-1:0];
          base_d    = in_base;
          is_load_d = ~in_ir[12];
          count_d   = '0;
`ifdef LMSM_BASE_WB_EN
          ra_d      = in_ir[11:9];
`endif
          state_d   = ST_ACTIVE;
        end
      end

      ST_ACTIVE: begin
        out_valid   = 1'b1;
        out_reg     = enc_idx;
        out_addr    = beat_addr;
        out_is_load = is_load_q;
`ifdef LMSM_BASE_WB_EN
        out_last    = 1'b0;
`else
        out_last    = list_single;
`endif
        if (out_ready) begin
          list_d  = list_q & ~clr_mask;
          count_d = count_q + 1'b1;
          if (list_single) begin
`ifdef LMSM_BASE_WB_EN
            state_d = ST_WB;
`else
            state_d = ST_IDLE;
`endif
          end
        end
      end

`ifdef LMSM_BASE_WB_EN
      ST_WB: begin
        // count now equals N, so the address points just past the block.
        out_valid   = 1'b1;
        out_reg     = ra_q;
        out_addr    = beat_addr;
        out_is_load = 1'b1;
        out_last    = 1'b1;
        wb_valid    = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
`endif

      default: state_d = ST_IDLE;
    endcase
  end

  assign r7_hit = out_valid && out_is_load && (out_reg == REG_AW'(R7_IDX));
  assign stall  = (state_q != ST_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; all of them are reset because each one is
  // architecturally visible after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      list_q    <= '0;
      base_q    <= '0;
      count_q   <= '0;
      is_load_q <= 1'b0;
`ifdef LMSM_BASE_WB_EN
      ra_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      list_q    <= list_d;
      base_q    <= base_d;
      count_q   <= count_d;
      is_load_q <= is_load_d;
`ifdef LMSM_BASE_WB_EN
      ra_q      <= ra_d;
`endif
    end
  end

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Directed self-checking bench for lmsm_sequencer (both LMSM_BASE_WB_EN builds).
module tb_lmsm_sequencer;

  localparam int DATA_W = 16;
  localparam int LIST_W = 8;
  localparam int REG_AW = 3;
`ifdef LMSM_BASE_WB_EN
  localparam bit WB = 1'b1;
`else
  localparam bit WB = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_ir;
  logic [DATA_W-1:0] in_base;
  logic              out_valid;
  logic              out_ready;
  logic [REG_AW-1:0] out_reg;
  logic [DATA_W-1:0] out_addr;
  logic              out_is_load;
  logic              out_last;
  logic              stall;
  logic              r7_hit;
`ifdef LMSM_BASE_WB_EN
  logic              wb_valid;
`endif

  int errors = 0;
  int checks = 0;

  lmsm_sequencer #(.DATA_W(DATA_W), .LIST_W(LIST_W), .REG_AW(REG_AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_ir       (in_ir),
    .in_base     (in_base),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_reg     (out_reg),
    .out_addr    (out_addr),
    .out_is_load (out_is_load),
    .out_last    (out_last),
`ifdef LMSM_BASE_WB_EN
    .wb_valid    (wb_valid),
`endif
    .stall       (stall),
    .r7_hit      (r7_hit)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, " in_ready"},    in_ready,    1);
    check({tag, " out_valid"},   out_valid,   0);
    check({tag, " stall"},       stall,       0);
    check({tag, " out_reg"},     out_reg,     0);
    check({tag, " out_addr"},    out_addr,    0);
    check({tag, " out_is_load"}, out_is_load, 0);
    check({tag, " out_last"},    out_last,    0);
    check({tag, " r7_hit"},      r7_hit,      0);
`ifdef LMSM_BASE_WB_EN
    check({tag, " wb_valid"},    wb_valid,    0);
`endif
  endtask

  task automatic check_idle(input string tag);
    check({tag, " in_ready"},  in_ready,  1);
    check({tag, " out_valid"}, out_valid, 0);
    check({tag, " stall"},     stall,     0);
  endtask

  task automatic check_beat(input string tag, input logic [2:0] r, input logic [15:0] a,
                            input logic ld, input logic last, input logic r7);
    check({tag, " out_valid"},   out_valid,   1);
    check({tag, " in_ready"},    in_ready,    0);
    check({tag, " stall"},       stall,       1);
    check({tag, " out_reg"},     out_reg,     r);
    check({tag, " out_addr"},    out_addr,    a);
    check({tag, " out_is_load"}, out_is_load, ld);
    check({tag, " out_last"},    out_last,    last);
    check({tag, " r7_hit"},      r7_hit,      r7);
`ifdef LMSM_BASE_WB_EN
    check({tag, " wb_valid"},    wb_valid,    0);
`endif
  endtask

`ifdef LMSM_BASE_WB_EN
  task automatic wb_tail(input string tag, input logic [2:0] ra, input logic [15:0] a);
    check({tag, " out_valid"},   out_valid,   1);
    check({tag, " wb_valid"},    wb_valid,    1);
    check({tag, " out_reg"},     out_reg,     ra);
    check({tag, " out_addr"},    out_addr,    a);
    check({tag, " out_is_load"}, out_is_load, 1);
    check({tag, " out_last"},    out_last,    1);
    check({tag, " stall"},       stall,       1);
    tick();
  endtask
`endif

  // Presents an instruction for one cycle; returns with the first beat visible.
  task automatic issue(input logic [15:0] ir, input logic [15:0] base);
    in_valid = 1'b1;
    in_ir    = ir;
    in_base  = base;
    tick();
    in_valid = 1'b0;
    in_ir    = 16'h0000;
    in_base  = 16'hDEAD;
  endtask

  logic [2:0] t1_reg [4];

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_ir     = '0;
    in_base   = '0;
    out_ready = 1'b0;
    t1_reg    = '{3'd0, 3'd2, 3'd5, 3'd7};

    repeat (2) tick();
    check_reset("reset");
    rst_n = 1'b1;
    tick();

    // Test 1: LM list A5 from base 0100, downstream always ready.
    out_ready = 1'b1;
    check_idle("t1 pre");
    issue(16'h60A5, 16'h0100);
    for (int i = 0; i < 4; i++) begin
      check_beat($sformatf("t1 beat%0d", i), t1_reg[i], 16'h0100 + 16'(i), 1'b1,
                 (i == 3) && !WB, t1_reg[i] == 3'd7);
      tick();
    end
`ifdef LMSM_BASE_WB_EN
    wb_tail("t1 wb", 3'd0, 16'h0104);
`endif
    check_idle("t1 post");

    // Test 2: SM with empty list is a NOP.
    issue(16'h7000, 16'h1234);
    check_idle("t2 a");
    tick();
    check_idle("t2 b");

    // Test 3: SM list 81 from FFFF with back-pressure on the first beat.
    out_ready = 1'b0;
    issue(16'h7081, 16'hFFFF);
    for (int k = 0; k < 3; k++) begin
      check_beat($sformatf("t3 hold%0d", k), 3'd0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    check_beat("t3 beat0", 3'd0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    tick();
    check_beat("t3 beat1", 3'd7, 16'h0000, 1'b0, !WB, 1'b0);
    tick();
`ifdef LMSM_BASE_WB_EN
    wb_tail("t3 wb", 3'd0, 16'h0001);
`endif
    check_idle("t3 post");

    // Test 4: reset during beat 2 of list FF, then a fresh LM restarts at count 0.
    issue(16'h60FF, 16'h0200);
    check_beat("t4 beat0", 3'd0, 16'h0200, 1'b1, 1'b0, 1'b0);
    tick();
    check_beat("t4 beat1", 3'd1, 16'h0201, 1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_reset("t4 async");
    tick();
    check_reset("t4 held");
    rst_n = 1'b1;
    tick();
    issue(16'h60C0, 16'h0300);
    check_beat("t4 new0", 3'd6, 16'h0300, 1'b1, 1'b0, 1'b0);
    tick();
    check_beat("t4 new1", 3'd7, 16'h0301, 1'b1, !WB, 1'b1);
    tick();
`ifdef LMSM_BASE_WB_EN
    wb_tail("t4 wb", 3'd0, 16'h0302);
`endif
    check_idle("t4 post");

    // Test 5: non-LM/SM opcode is ignored.
    in_valid = 1'b1;
    in_ir    = 16'h00A5;
    in_base  = 16'h0500;
    tick();
    check_idle("t5 a");
    tick();
    check_idle("t5 b");
    in_valid = 1'b0;
    tick();
    check_idle("t5 c");

`ifdef LMSM_BASE_WB_EN
    // Test 6: LM RA=3, list 03, base 0040, then base write-back beat.
    issue(16'h6603, 16'h0040);
    check_beat("t6 beat0", 3'd0, 16'h0040, 1'b1, 1'b0, 1'b0);
    tick();
    check_beat("t6 beat1", 3'd1, 16'h0041, 1'b1, 1'b0, 1'b0);
    tick();
    wb_tail("t6 wb", 3'd3, 16'h0042);
    check_idle("t6 post");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
